// File: rtl/sram_ctrl_pkg.sv
// Shared types for the 64x52 single-port SRAM request front-end.
package sram_ctrl_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 52;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_resp_fifo.sv
// Small circular response FIFO; head is the registered entry at the read pointer.
module sram_resp_fifo #(
  parameter int DEPTH = 3,
  parameter int W     = 52,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count
);

  localparam int             PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr] <= push_data;
        r_wr        <= (r_wr == LAST) ? '0 : r_wr + 1'b1;
      end
      if (pop)
        r_rd <= (r_rd == LAST) ? '0 : r_rd + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head  = r_mem[r_rd];
  assign count = r_count;

  // The upstream credit gate makes both of these unreachable.
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && r_count == FULL));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && r_count == '0));

endmodule

// File: rtl/sram_1rw_ctrl.sv
// Valid/ready front-end for the single-port SRAM with a credit-gated response FIFO.
// Define SRAM_CTRL_INIT_EN to zero-fill the whole array after every reset.
module sram_1rw_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RESP_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              sram_en,
  output logic              sram_write,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int DEPTH = 2 ** ADDR_W;

  ctrl_state_t      r_st;
  ctrl_state_t      w_st_nxt;
  logic             r_rd_pend;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W:0]   w_used;
  logic             w_credit;
  logic             w_req_ready;
  logic             w_en;
  logic             w_pop;
  sram_req_t        w_req;

  // A read in flight already owns a FIFO slot, so it counts against the credit.
  assign w_used   = (CNT_W + 1)'(w_cnt) + (CNT_W + 1)'(r_rd_pend);
  assign w_credit = w_used < (CNT_W + 1)'(RESP_DEPTH);

`ifdef SRAM_CTRL_INIT_EN
  logic [ADDR_W-1:0] r_init_cnt;
  logic              w_busy;

  always_ff @(posedge clk) begin
    if (rst)
      r_init_cnt <= '0;
    else if (r_st == ST_INIT)
      r_init_cnt <= r_init_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_st <= ST_INIT;
    else     r_st <= w_st_nxt;
  end

  assign busy = w_busy;
`else
  always_ff @(posedge clk) begin
    if (rst) r_st <= ST_RUN;
    else     r_st <= w_st_nxt;
  end

  assign busy = 1'b0;
`endif

  always_comb begin
    w_st_nxt     = r_st;
    w_req_ready  = 1'b0;
    w_en         = 1'b0;
    w_req.write  = req_write;
    w_req.addr   = req_addr;
    w_req.wdata  = req_wdata;
`ifdef SRAM_CTRL_INIT_EN
    w_busy       = 1'b0;
`endif
    if (!rst) begin
      case (r_st)
`ifdef SRAM_CTRL_INIT_EN
        ST_INIT: begin
          w_busy      = 1'b1;
          w_en        = 1'b1;
          w_req.write = 1'b1;
          w_req.addr  = r_init_cnt;
          w_req.wdata = '0;
          if (r_init_cnt == ADDR_W'(DEPTH - 1))
            w_st_nxt = ST_RUN;
        end
`endif
        ST_RUN: begin
          w_req_ready = w_credit;
          w_en        = req_valid & w_credit;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_rd_pend <= 1'b0;
    else     r_rd_pend <= w_en & ~w_req.write;
  end

  assign resp_valid = ~rst & (w_cnt != '0);
  assign w_pop      = resp_valid & resp_ready;

  sram_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .W     (DATA_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (r_rd_pend),
    .push_data (sram_rdata),
    .pop       (w_pop),
    .head      (resp_rdata),
    .count     (w_cnt)
  );

  assign req_ready  = w_req_ready;
  assign sram_en    = w_en;
  assign sram_write = w_req.write;
  assign sram_addr  = w_req.addr;
  assign sram_wdata = w_req.wdata;

endmodule
